ssram_arbiter: RTL and testbench

SSRAM_ARBITER -- requirements
Module: ssram_arbiter

---
 rtl/ssram_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ssram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssram_arbiter.sv
// -----------------------------------------------------------------------------
// ssram_arbiter
//
// Two-requester arbiter in front of a single-port synchronous SRAM. Requester
// A (host) and requester B (core) each issue single read or write commands
// with a req/ack handshake. The winner's command is latched and then driven
// onto the SSRAM bus. Addresses at or above DEPTH are not sent to the SSRAM.
// They complete with an error flag instead.
//
// Transaction timeline, counted in cycles after the request is sampled in IDLE:
//   write            : IDLE -> CMD (mem_we/mem_oe) -> ACK                 (ack at +2)
//   read             : IDLE -> CMD (mem_re) -> WAIT x RD_LAT -> ACK       (ack at +2+RD_LAT)
//   out-of-range     : IDLE -> CMD (no strobe) -> ACK with err=1          (ack at +2)
//
// Configuration macro:
//   SSRAM_ARB_RR_EN  defined   : simultaneous requests are granted round-robin.
//                               The requester that was not granted last wins.
//                    undefined : A always wins simultaneous requests (fixed priority).
//
// Parameters:
//   DW      data width
//   AW      address width
//   DEPTH   number of implemented SSRAM words (valid addresses 0..DEPTH-1)
//   RD_LAT  cycles from mem_re to valid mem_rdata (legal range 1..4)
//
// Ports:
//   clk, rst                     clock; asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata    requester A command (we: 1=write, 0=read)
//   a_ack/a_err/a_rdata          requester A completion, error, read data
//   b_*                          requester B, same as A
//   mem_we/mem_re                SSRAM write / read strobes
//   mem_addr/mem_wdata/mem_oe    SSRAM address, write data, data-bus drive enable
//   mem_rdata                    SSRAM read data
// -----------------------------------------------------------------------------
module ssram_arbiter #(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,

    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_oe,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    // The wait counter runs 0..RD_LAT-1. Two bits cover the full legal range 1..4.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);
    // One extra bit lets DEPTH reach 2**AW without wrapping to zero.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    state_t        state;
    state_t        state_next;
    sel_t          grant;        // requester owning the transaction in flight
    sel_t          grant_next;   // arbitration result, used only in IDLE

    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [1:0]    wait_cnt;

    logic          any_req;
    logic          in_range;
    logic          wait_done;

    assign any_req   = a_req | b_req;
    assign in_range  = ({1'b0, cmd_addr} < DEPTH_LIM);
    assign wait_done = (wait_cnt == WAIT_LAST);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef SSRAM_ARB_RR_EN
    sel_t last_grant;

    always_comb begin
        if (a_req && b_req) begin
            grant_next = (last_grant == SEL_A) ? SEL_B : SEL_A;
        end else if (a_req) begin
            grant_next = SEL_A;
        end else begin
            grant_next = SEL_B;
        end
    end

    // Reset to B, so A wins the first simultaneous request after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SEL_B;
        end else if (state == IDLE && any_req) begin
            last_grant <= grant_next;
        end
    end
`else
    always_comb begin
        grant_next = a_req ? SEL_A : SEL_B;
    end
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // Strobes, acks and the bus are decoded from the registered state. This
    // lets an asynchronous reset drop them at once without waiting for a clock
    // edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case statement, so no
        // path through the block leaves a value unassigned (no latches).
        state_next = state;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_oe     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        a_ack      = 1'b0;
        b_ack      = 1'b0;
        a_err      = 1'b0;
        b_err      = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = CMD;
                end
            end

            CMD: begin
                mem_addr  = cmd_addr;
                mem_wdata = cmd_wdata;
                if (!in_range) begin
                    state_next = ACK;
                end else if (cmd_we) begin
                    mem_we     = 1'b1;
                    mem_oe     = 1'b1;
                    state_next = ACK;
                end else begin
                    mem_re     = 1'b1;
                    state_next = WAIT;
                end
            end

            WAIT: begin
                mem_addr  = cmd_addr;
                mem_wdata = cmd_wdata;
                if (wait_done) begin
                    state_next = ACK;
                end
            end

            ACK: begin
                mem_addr   = cmd_addr;
                mem_wdata  = cmd_wdata;
                a_ack      = (grant == SEL_A);
                b_ack      = (grant == SEL_B);
                a_err      = (grant == SEL_A) && !in_range;
                b_err      = (grant == SEL_B) && !in_range;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command latch, wait counter and per-requester read data
    // The command is captured only in IDLE. Requesters may therefore change
    // their inputs freely while a transaction is in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= SEL_B;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            wait_cnt  <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= grant_next;
                        if (grant_next == SEL_A) begin
                            cmd_we    <= a_we;
                            cmd_addr  <= a_addr;
                            cmd_wdata <= a_wdata;
                        end else begin
                            cmd_we    <= b_we;
                            cmd_addr  <= b_addr;
                            cmd_wdata <= b_wdata;
                        end
                    end
                end

                CMD: begin
                    wait_cnt <= '0;
                    // An out-of-range read still counts as a read completion.
                    // It returns zero data.
                    if (!in_range && !cmd_we) begin
                        if (grant == SEL_A) begin
                            a_rdata <= '0;
                        end else begin
                            b_rdata <= '0;
                        end
                    end
                end

                WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    // Capture on the final WAIT edge so data is stable during ACK.
                    if (wait_done) begin
                        if (grant == SEL_A) begin
                            a_rdata <= mem_rdata;
                        end else begin
                            b_rdata <= mem_rdata;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ssram_arbiter
//
// Self-checking bench for ssram_arbiter. A behavioural SSRAM with RD_LAT-cycle
// read latency sits on the memory port. The reference model is an array of
// expected memory contents plus expected per-requester read data. Latency,
// strobe counts, error flags and grant order come from the transaction-level
// rules of the block. The bench drives directed and randomized transactions
// and checks each one.
// -----------------------------------------------------------------------------
module tb_ssram_arbiter;

    localparam int DW     = 16;
    localparam int AW     = 8;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req, a_we, a_ack, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_ack, b_err;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_we, mem_re, mem_oe;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rdata [2];
    bit            last_b;

    always #5 clk = ~clk;

    ssram_arbiter #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_rdata(mem_rdata)
    );

    // ---------------- behavioural SSRAM ----------------
    logic [DW-1:0] ssram   [DEPTH];
    logic [DW-1:0] rd_pipe [RD_LAT];

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(32'hA5C3 ^ (i * 32'h0107));
    endfunction

    assign mem_rdata = rd_pipe[RD_LAT-1];

    initial begin
        for (int i = 0; i < DEPTH; i++) ssram[i] = init_word(i);
        for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;
        forever begin
            @(posedge clk);
            if (mem_we && int'(mem_addr) < DEPTH) ssram[mem_addr] <= mem_wdata;
            for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
            // Data is valid only RD_LAT cycles after the strobe. X otherwise.
            rd_pipe[0] <= mem_re ? ssram[mem_addr] : 'x;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit who_b, input logic r, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (who_b) {b_req, b_we, b_addr, b_wdata} = {r, we, addr, wd};
        else       {a_req, a_we, a_addr, a_wdata} = {r, we, addr, wd};
    endtask

    // One transaction from one requester, started #1 after a rising edge with
    // the DUT in IDLE. Ends #1 after the following edge, back in IDLE.
    task automatic run_txn(input bit who_b, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input bit scramble, input string name);
        int            lat    = 0;
        int            n_we   = 0;
        int            n_re   = 0;
        int            n_bad  = 0;
        bit            got    = 0;
        bit            other  = 0;
        logic          obs_err = 1'bx;
        logic [DW-1:0] obs_rd  = 'x;
        logic [AW-1:0] s_addr  = '0;
        logic [DW-1:0] s_wd    = '0;
        bit            in_rng;
        int            exp_lat;

        in_rng  = int'(addr) < DEPTH;
        exp_lat = (in_rng && !we) ? 2 + RD_LAT : 2;
        drive(who_b, 1'b1, we, addr, wd);
        while (!got && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (scramble && lat == 1)
                drive(who_b, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
            if (mem_we) begin n_we++; s_addr = mem_addr; s_wd = mem_wdata; end
            if (mem_re) begin n_re++; s_addr = mem_addr; end
            if ((mem_we && mem_re) || (mem_oe !== mem_we)) n_bad++;
            if (who_b ? a_ack : b_ack) other = 1;
            if (who_b ? b_ack : a_ack) begin
                got     = 1;
                obs_err = who_b ? b_err : a_err;
                obs_rd  = who_b ? b_rdata : a_rdata;
            end
        end
        drive(who_b, 1'b0, 1'b0, '0, '0);

        // reference model update
        if (we && in_rng) ref_mem[addr] = wd;
        if (!we) exp_rdata[who_b] = in_rng ? ref_mem[addr] : '0;
        last_b = who_b;

        check({name, " latency"},     32'(lat),   32'(exp_lat));
        check({name, " err"},         32'(obs_err), 32'(!in_rng));
        check({name, " we strobes"},  32'(n_we),  (we && in_rng) ? 32'd1 : 32'd0);
        check({name, " re strobes"},  32'(n_re),  (!we && in_rng) ? 32'd1 : 32'd0);
        check({name, " strobe rule"}, 32'(n_bad), 32'd0);
        check({name, " other ack"},   32'(other), 32'd0);
        if (in_rng) check({name, " mem_addr"}, 32'(s_addr), 32'(addr));
        if (we && in_rng) check({name, " mem_wdata"}, 32'(s_wd), 32'(wd));
        check({name, " rdata"}, 32'(obs_rd), 32'(exp_rdata[who_b]));
        check({name, " other rdata"}, 32'(who_b ? a_rdata : b_rdata), 32'(exp_rdata[!who_b]));

        @(posedge clk); #1;
        check({name, " ack one cycle"}, 32'({a_ack, b_ack}), 32'd0);
        check({name, " idle bus"},      32'({mem_addr, mem_wdata}), 32'd0);
    endtask

    // Both requesters hold reads. Records the first four acks.
    task automatic arb_test();
        logic [AW-1:0] addr_a, addr_b;
        bit            seq[$];
        bit            exp_b;
        int            cyc  = 0;
        int            both = 0;

        addr_a = AW'($urandom_range(0, DEPTH - 1));
        addr_b = AW'($urandom_range(0, DEPTH - 1));
        {a_req, a_we, a_addr, a_wdata} = {1'b1, 1'b0, addr_a, 16'h0};
        {b_req, b_we, b_addr, b_wdata} = {1'b1, 1'b0, addr_b, 16'h0};
        while (seq.size() < 4 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (a_ack && b_ack) both++;
            if (a_ack) begin
                seq.push_back(1'b0);
                check("arb a_rdata", 32'(a_rdata), 32'(ref_mem[addr_a]));
            end else if (b_ack) begin
                seq.push_back(1'b1);
                check("arb b_rdata", 32'(b_rdata), 32'(ref_mem[addr_b]));
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("arb ack count", 32'(seq.size()), 32'd4);
        check("arb dual ack",  32'(both),       32'd0);

        exp_b = last_b;
        for (int i = 0; i < 4; i++) begin
`ifdef SSRAM_ARB_RR_EN
            exp_b = !exp_b;
`else
            exp_b = 1'b0;
`endif
            check($sformatf("arb grant %0d", i),
                  (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF_FFFF, 32'(exp_b));
            if (exp_b) exp_rdata[1] = ref_mem[addr_b];
            else       exp_rdata[0] = ref_mem[addr_a];
        end
        last_b = exp_b;

        @(posedge clk); #1;
        check("arb idle bus", 32'({mem_addr, mem_wdata}), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit            who;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;

        {a_req, a_we, a_addr, a_wdata} = '0;
        {b_req, b_we, b_addr, b_wdata} = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_b       = 1'b1;

        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack/err",   32'({a_ack, b_ack, a_err, b_err}), 32'd0);
        check("reset a_rdata",   32'(a_rdata), 32'd0);
        check("reset b_rdata",   32'(b_rdata), 32'd0);
        check("reset strobes",   32'({mem_we, mem_re, mem_oe}), 32'd0);
        check("reset mem_addr",  32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // basic write, read-back, out-of-range
        run_txn(1'b0, 1'b1, 8'h05, 16'h1234, 1'b0, "A write 05");
        run_txn(1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, "B read 05");
        run_txn(1'b0, 1'b0, 8'h05, 16'h0000, 1'b0, "A read 05");
        run_txn(1'b0, 1'b0, 8'h40, 16'h0000, 1'b0, "A read 40 oor");
        run_txn(1'b1, 1'b1, 8'hFF, 16'hBEEF, 1'b0, "B write FF oor");
        run_txn(1'b1, 1'b0, 8'h3F, 16'h0000, 1'b0, "B read 3F top");

        // randomized single-requester traffic, some with inputs changed mid-flight
        for (int n = 0; n < 40; n++) begin
            who  = 1'($urandom);
            we   = 1'($urandom);
            addr = AW'($urandom_range(0, DEPTH + 15));
            wd   = DW'($urandom);
            run_txn(who, we, addr, wd, 1'($urandom), $sformatf("rnd %0d", n));
        end

        // simultaneous held reads
        arb_test();

        // reset during WAIT of a B read
        drive(1'b1, 1'b1, 1'b0, 8'h05, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset mem_addr", 32'(mem_addr), 32'h05);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        check("mid reset strobes", 32'({mem_we, mem_re, mem_oe}), 32'd0);
        check("mid reset acks",    32'({a_ack, b_ack}), 32'd0);
        check("mid reset bus",     32'({mem_addr, mem_wdata}), 32'd0);
        check("mid reset rdata",   32'({a_rdata, b_rdata}), 32'd0);
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_b       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("held reset acks", 32'({a_ack, b_ack, mem_re}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 1'b1, 8'h21, 16'hC0DE, 1'b0, "post-reset A write");
        run_txn(1'b0, 1'b0, 8'h21, 16'h0000, 1'b0, "post-reset A read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
